// File: rtl/fadd_pipe.sv
// Pipelined IEEE-754 adder/subtractor with parametrised exponent/mantissa widths,
// round-to-nearest-even, overflow/invalid flags and a globally stalled valid/ready pipeline.
module fadd_pipe #(
  parameter int unsigned EW = 8,
  parameter int unsigned MW = 23,
  localparam int unsigned W = 1 + EW + MW
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         ovf,
  output logic         inv
);
  localparam int unsigned SW   = MW + 4;
  localparam int unsigned LZW  = $clog2(SW + 1);
  localparam int unsigned EMAX = (32'd1 << EW) - 32'd1;
  localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  typedef struct packed {
    logic         valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } s0_t;

  typedef struct packed {
    logic          valid;
    logic          sign;
    logic          eff_sub;
    logic [EW-1:0] exp;
    logic [SW-1:0] sig_l;
    logic [SW-1:0] sig_s;
    logic          spec;
    logic          spec_inv;
    logic [W-1:0]  spec_y;
  } s1_t;

  typedef struct packed {
    logic           valid;
    logic           sign;
    logic           eff_sub;
    logic [EW-1:0]  exp;
    logic [SW:0]    sum;
    logic [LZW-1:0] lzc;
    logic           spec;
    logic           spec_inv;
    logic [W-1:0]   spec_y;
  } s2_t;

  function automatic logic [LZW-1:0] lzc_f(input logic [SW-1:0] v);
    lzc_f = LZW'(SW);
    for (int i = 0; i < int'(SW); i++) begin
      if (v[i]) lzc_f = LZW'(int'(SW) - 1 - i);
    end
  endfunction

  s0_t s0_d, s0_q;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic         out_valid_q;
  logic [W-1:0] y_d, y_q;
  logic         ovf_d, ovf_q, inv_d, inv_q;
  logic         advance;

  assign advance   = !out_valid_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign inv       = inv_q;

  // Operand capture; the subtract flag is folded into B's sign here
  always_comb begin
    s0_d       = '0;
    s0_d.valid = in_valid;
    s0_d.a     = x1;
    s0_d.b     = {x2[W-1] ^ sub, x2[W-2:0]};
  end

  logic          sa, sb, a_sub, b_sub, a_nan, b_nan, a_inf, b_inf, a_ge, sticky;
  logic [EW-1:0] ea, eb, eea, eeb, d;
  logic [MW-1:0] ma, mb;
  logic [SW-1:0] sig_a, sig_b, sig_sm, sig_sh;

  // Stage 1: unpack, classify, order by magnitude, align the smaller significand
  always_comb begin
    sa     = s0_q.a[W-1];
    sb     = s0_q.b[W-1];
    ea     = s0_q.a[W-2:MW];
    eb     = s0_q.b[W-2:MW];
    ma     = s0_q.a[MW-1:0];
    mb     = s0_q.b[MW-1:0];
    a_sub  = (ea == '0);
    b_sub  = (eb == '0);
    a_nan  = (&ea) & (|ma);
    b_nan  = (&eb) & (|mb);
    a_inf  = (&ea) & ~(|ma);
    b_inf  = (&eb) & ~(|mb);
    eea    = a_sub ? EW'(1) : ea;
    eeb    = b_sub ? EW'(1) : eb;
    sig_a  = {~a_sub, ma, 3'b000};
    sig_b  = {~b_sub, mb, 3'b000};
    a_ge   = ({ea, ma} >= {eb, mb});
    s1_d   = '0;
    s1_d.valid   = s0_q.valid;
    s1_d.eff_sub = sa ^ sb;
    if (a_ge) begin
      s1_d.sign  = sa;
      s1_d.exp   = eea;
      s1_d.sig_l = sig_a;
      sig_sm     = sig_b;
      d          = eea - eeb;
    end else begin
      s1_d.sign  = sb;
      s1_d.exp   = eeb;
      s1_d.sig_l = sig_b;
      sig_sm     = sig_a;
      d          = eeb - eea;
    end
    if (32'(d) >= SW) begin
      sig_sh = '0;
      sticky = |sig_sm;
    end else begin
      sig_sh = sig_sm >> d;
      sticky = |(sig_sm & ~({SW{1'b1}} << d));
    end
    s1_d.sig_s = {sig_sh[SW-1:1], sig_sh[0] | sticky};
    if (a_nan | b_nan) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_inv = 1'b1;
      s1_d.spec_y   = QNAN;
    end else if (a_inf & b_inf & (sa != sb)) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_inv = 1'b1;
      s1_d.spec_y   = QNAN;
    end else if (a_inf) begin
      s1_d.spec   = 1'b1;
      s1_d.spec_y = {sa, {EW{1'b1}}, {MW{1'b0}}};
    end else if (b_inf) begin
      s1_d.spec   = 1'b1;
      s1_d.spec_y = {sb, {EW{1'b1}}, {MW{1'b0}}};
    end
  end

  // Stage 2: magnitude add/subtract (never negative thanks to ordering) and leading-zero count
  always_comb begin
    s2_d          = '0;
    s2_d.valid    = s1_q.valid;
    s2_d.sign     = s1_q.sign;
    s2_d.eff_sub  = s1_q.eff_sub;
    s2_d.exp      = s1_q.exp;
    s2_d.spec     = s1_q.spec;
    s2_d.spec_inv = s1_q.spec_inv;
    s2_d.spec_y   = s1_q.spec_y;
    s2_d.sum      = s1_q.eff_sub ? ({1'b0, s1_q.sig_l} - {1'b0, s1_q.sig_s})
                                 : ({1'b0, s1_q.sig_l} + {1'b0, s1_q.sig_s});
    s2_d.lzc      = lzc_f(s2_d.sum[SW-1:0]);
  end

  logic [SW-1:0] norm;
  logic [MW+1:0] mant;
  int unsigned   e_i, sh_i;
  logic          rnd_up, res_ovf, res_inv;
  logic [W-1:0]  res;

  // Stage 3: normalise (left shift floored at exponent 1), round ties-to-even, pack
  always_comb begin
    norm    = '0;
    mant    = '0;
    e_i     = 32'(s2_q.exp);
    sh_i    = 0;
    rnd_up  = 1'b0;
    res     = '0;
    res_ovf = 1'b0;
    res_inv = 1'b0;
    if (s2_q.sum[SW]) begin
      norm = {s2_q.sum[SW:2], s2_q.sum[1] | s2_q.sum[0]};
      e_i  = e_i + 1;
    end else begin
      sh_i = (32'(s2_q.lzc) < e_i - 1) ? 32'(s2_q.lzc) : e_i - 1;
      norm = s2_q.sum[SW-1:0] << sh_i;
      e_i  = e_i - sh_i;
    end
    rnd_up = norm[2] & (norm[3] | norm[1] | norm[0]);
    mant   = {1'b0, norm[SW-1:3]} + {{(MW+1){1'b0}}, rnd_up};
    if (mant[MW+1]) begin
      mant = mant >> 1;
      e_i  = e_i + 1;
    end
    if (s2_q.spec) begin
      res     = s2_q.spec_y;
      res_inv = s2_q.spec_inv;
    end else if (s2_q.sum == '0) begin
      res = {s2_q.sign & ~s2_q.eff_sub, {(W-1){1'b0}}};
    end else if (e_i >= EMAX) begin
      res     = {s2_q.sign, {EW{1'b1}}, {MW{1'b0}}};
      res_ovf = 1'b1;
    end else begin
      res = {s2_q.sign, (mant[MW] ? EW'(e_i) : {EW{1'b0}}), mant[MW-1:0]};
    end
    y_d   = s2_q.valid ? res : '0;
    ovf_d = s2_q.valid & res_ovf;
    inv_d = s2_q.valid & res_inv;
  end

  // All ranks advance together; a stalled output freezes the whole pipe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else if (advance) begin
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      out_valid_q <= s2_q.valid;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      inv_q       <= inv_d;
    end
  end

endmodule

// File: doc/fadd_pipe.md
# fadd_pipe

Pipelined, parametrised IEEE-754 binary floating-point adder/subtractor with valid/ready handshaking. It generalises the team's combinational single-precision adder to arbitrary exponent/mantissa widths, adds a subtract mode, correct round-to-nearest-even, invalid-operation flagging and a three-stage pipeline with backpressure. It sits between operand issue and result writeback in the FPU datapath.

## Interface
- EW, default 8: exponent field width (≥ 4).
- MW, default 23: stored mantissa field width (≥ 4); word width W = 1+EW+MW.
- clk  in  1  rising-edge clock.
- rstn  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  pipeline can accept this cycle.
- x1  in  W  operand A.
- x2  in  W  operand B.
- sub  in  1  1: compute x1 − x2 (x2 sign inverted before all processing).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- y  out  W  result.
- ovf  out  1  finite operands rounded to infinity.
- inv  out  1  invalid operation (inf − inf, or any NaN input).

## Operation
- Stage 1: unpack; subnormals get implicit bit 0 and effective exponent 1; classify zero/sub/normal/inf/NaN; order by magnitude (exponent, then mantissa); right-shift smaller significand by exponent difference into MW+4 bits (hidden, MW, guard, round, sticky); sticky = OR of all bits shifted out; shift ≥ MW+4 leaves only sticky.
- Stage 2: same effective sign → add (one carry bit); different → larger minus smaller, never negative; result sign = sign of larger magnitude; leading-zero count of sum.
- Stage 3: normalise: carry → shift right 1 with sticky OR, exponent +1; else shift left by min(lzc, exp−1) (gradual underflow, exponent floor 1, encoded 0 if hidden bit clear); round to nearest, ties to even; rounding carry-out renormalises, exponent +1; exponent ≥ 2^EW−1 → ±inf, ovf=1.
- Special results, priority order: any NaN → canonical qNaN {0, all-ones, 1, zeros}, inv=1; inf + inf of opposite effective sign → canonical qNaN, inv=1; one inf → that inf; exact zero from opposite-sign operands → +0; (−0)+(−0) → −0; zero operand → other operand unchanged (after sub sign flip).
- ovf and inv never both 1; both 0 whenever out_valid=0.

## Timing
- Latency 3: operands accepted at edge t (in_valid & in_ready) appear with out_valid=1 after edge t+3 absent stalls; throughput 1/cycle.
- Global stall: advance = !out_valid | out_ready; in_ready = advance (combinational from out_ready). When advance=0 all stage registers hold, including y/ovf/inv.
- Bubbles: in_valid=0 on an advancing cycle inserts a bubble; bubbles collapse only by draining, not compaction.
- y, ovf, inv stable while out_valid=1 and out_ready=0.
- Reset (any time, including mid-stream): all stage valids, out_valid, y, ovf, inv → 0 immediately; in-flight operations discarded; in_ready=1 after reset release.
- x1/x2/sub sampled only on accept; ignored otherwise.

## Test plan
- Defaults, sub=0: 3F800000 + 3F800000 → y=40000000, ovf=0, inv=0, out_valid 3 cycles after accept.
- Rounding ties: 3F800000 + 33800000 → 3F800000; 3F800001 + 33800000 → 3F800002; sub=1, 3F800000 − 3F800000 → 00000000.
- Overflow/specials: 7F7FFFFF + 7F7FFFFF → 7F800000, ovf=1; 7F800000 + FF800000 → 7FC00000, inv=1; 7FA00000 + 3F800000 → 7FC00000, inv=1.
- Subnormals: 00000001 + 00000001 → 00000002; 00400000 + 00400000 → 00800000; 80000000 + 80000000 → 80000000.
- Backpressure: stream 8 back-to-back adds, hold out_ready=0 for 5 cycles mid-stream → in_ready=0 while held, all 8 results emitted once, in order, values unchanged during stall.
- Reset mid-stream with 3 in flight, plus a reduced-format instance (EW=5, MW=10): 3C00 + 3C00 → 4000; 7BFF + 7BFF → 7C00, ovf=1; reset drops out_valid to 0 with no stale output afterwards.
